// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache to main-memory line arbiter.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration
// (used by mem_arb_pick); without it D-cache has fixed priority over I-cache.
package mem_arb_pkg;

    localparam int ARB_ADDR_WIDTH   = 32;
    localparam int ARB_LINE_WIDTH   = 128;
    localparam int LINE_OFFSET_BITS = 4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic                      wen;
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic [ARB_LINE_WIDTH-1:0] wdata;
    } line_req_t;

    // Memory only ever sees whole lines, so the byte offset within the line is dropped.
    function automatic logic [ARB_ADDR_WIDTH-1:0] line_align(input logic [ARB_ADDR_WIDTH-1:0] addr);
        return {addr[ARB_ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// MEM_ARB_RR_EN defined: round-robin on a tie (the requester that did not win
// last time goes first). Undefined: fixed priority, D always beats I.
// In both modes a lone requester wins immediately.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant,
    output logic any
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on a tie hand the port to whoever was not served last.
    always_comb begin
        any   = i_req | d_req;
        grant = GRANT_I;
        if (i_req && d_req) begin
            grant = ~last_grant;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end
`else
    // Fixed priority: the last grantee plays no part, so it is parked on an unused net.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: any D request wins; I only gets the port when D is quiet.
    always_comb begin
        any   = i_req | d_req;
        grant = GRANT_I;
        if (d_req) begin
            grant = GRANT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory line port between the I-cache and D-cache.
// One whole-line transaction at a time: IDLE (arbitrate and register the
// winner's request) -> MEM (hold the request until memory completes) ->
// RESP (one-cycle ready pulse to the winner with the returned line).
// Build macro MEM_ARB_RR_EN (see mem_arb_pick) switches tie-breaking from
// fixed D-over-I priority to round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int LINE_WIDTH = ARB_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_i,
    input  logic                  i_wen_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [LINE_WIDTH-1:0] i_wdata_i,
    output logic                  i_ready_o,

    input  logic                  d_req_i,
    input  logic                  d_wen_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [LINE_WIDTH-1:0] d_wdata_i,
    output logic                  d_ready_o,

    output logic [LINE_WIDTH-1:0] rdata_o,

    output logic                  mem_valid_o,
    output logic                  mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,

    output logic                  grant_o
);

    arb_state_e state;
    line_req_t  sel_line;
    logic       pick_grant;
    logic       pick_any;

    // grant_o doubles as the round-robin pointer: it always names the last grantee,
    // and resets to I so that D is favoured on the first tie.
    mem_arb_pick u_pick (
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .last_grant (grant_o),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    // Steer the winning requester's fields so IDLE can register them in one go.
    always_comb begin
        sel_line.wen   = i_wen_i;
        sel_line.addr  = i_addr_i;
        sel_line.wdata = i_wdata_i;
        if (pick_grant == GRANT_D) begin
            sel_line.wen   = d_wen_i;
            sel_line.addr  = d_addr_i;
            sel_line.wdata = d_wdata_i;
        end
    end

    // Transaction FSM with registered outputs. Requests are only looked at in IDLE,
    // so the winner's inputs may wander during MEM/RESP without effect, and
    // mem_ready_i outside MEM is ignored. Reset abandons any in-flight operation
    // without issuing a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_valid_o <= 1'b0;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            grant_o     <= GRANT_I;
            rdata_o     <= '0;
            i_ready_o   <= 1'b0;
            d_ready_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        mem_valid_o <= 1'b1;
                        mem_wen_o   <= sel_line.wen;
                        mem_addr_o  <= line_align(sel_line.addr);
                        mem_wdata_o <= sel_line.wdata;
                        grant_o     <= pick_grant;
                        state       <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ready_i) begin
                        rdata_o     <= mem_rdata_i;
                        mem_valid_o <= 1'b0;
                        i_ready_o   <= (grant_o == GRANT_I);
                        d_ready_o   <= (grant_o == GRANT_D);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    i_ready_o <= 1'b0;
                    d_ready_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
